// File: rtl/sbox_preprocess_stream.sv
// Stream front end for a composite-field AES S-box.
// Each accepted 32-bit word is mapped lane by lane into the composite-field
// basis (through the inverse affine step first when decrypting) and queued in
// a small FIFO together with its mode bit and a block-last marker.
module sbox_preprocess_stream #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_encrypt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_encrypt,
  output logic        out_last,
  input  logic        err_clr,
  output logic        mode_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  // Polynomial basis to composite-field basis; the inverse of delta_inv
  function automatic logic [7:0] delta(input logic [7:0] x);
    logic [7:0] d;
    d[7] = x[7] ^ x[5];
    d[6] = x[7] ^ x[6] ^ x[4] ^ x[3] ^ x[2] ^ x[1];
    d[5] = x[7] ^ x[5] ^ x[3] ^ x[2];
    d[4] = x[7] ^ x[5] ^ x[3] ^ x[2] ^ x[1];
    d[3] = x[7] ^ x[6] ^ x[2] ^ x[1];
    d[2] = x[7] ^ x[4] ^ x[3] ^ x[2] ^ x[1];
    d[1] = x[6] ^ x[4] ^ x[1];
    d[0] = x[6] ^ x[1] ^ x[0];
    return d;
  endfunction

  // Inverse AES affine transform: rotations 2, 5 and 7 plus constant 0x05
  function automatic logic [7:0] invAff(input logic [7:0] x);
    logic [7:0] y;
    y[0] = x[2] ^ x[5] ^ x[7];
    y[1] = x[3] ^ x[6] ^ x[0];
    y[2] = x[4] ^ x[7] ^ x[1];
    y[3] = x[5] ^ x[0] ^ x[2];
    y[4] = x[6] ^ x[1] ^ x[3];
    y[5] = x[7] ^ x[2] ^ x[4];
    y[6] = x[0] ^ x[3] ^ x[5];
    y[7] = x[1] ^ x[4] ^ x[6];
    return y ^ 8'h05;
  endfunction

  function automatic logic [7:0] mapLane(input logic [7:0] x, input logic enc);
    return enc ? delta(x) : delta(invAff(x));
  endfunction

  logic [31:0]   dataMem_q [FIFO_DEPTH];
  logic          encMem_q  [FIFO_DEPTH];
  logic          lastMem_q [FIFO_DEPTH];
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] wrPtr_q, wrPtr_d;
  logic [AW-1:0] rdPtr_q, rdPtr_d;
  logic [1:0]    widx_q, widx_d;
  logic          mode_q, mode_d;
  logic          modeErr_q, modeErr_d;

  logic          push;
  logic          pop;
  logic          violation;
  logic [31:0]   mappedWord;

  // Handshake: ready is held low throughout reset, otherwise only space matters
  always_comb begin
    in_ready    = rst_n && (count_q < DEPTH_C);
    out_valid   = (count_q != '0);
    push        = in_valid && in_ready;
    pop         = out_valid && out_ready;
    out_data    = out_valid ? dataMem_q[rdPtr_q] : 32'h0;
    out_encrypt = out_valid ? encMem_q[rdPtr_q] : 1'b0;
    out_last    = out_valid ? lastMem_q[rdPtr_q] : 1'b0;
    mode_err    = modeErr_q;
  end

  // Lane mapping of the incoming word, each lane using the word's own mode bit
  always_comb begin
    mappedWord = 32'h0;
    for (int i = 0; i < 4; i++) begin
      mappedWord[8*i +: 8] = mapLane(in_data[8*i +: 8], in_encrypt);
    end
  end

  // Next-state for occupancy, pointers, block framing and mode checking
  always_comb begin
    count_d   = count_q;
    wrPtr_d   = wrPtr_q;
    rdPtr_d   = rdPtr_q;
    widx_d    = widx_q;
    mode_d    = mode_q;
    violation = 1'b0;
    modeErr_d = modeErr_q;

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (push) begin
      wrPtr_d = wrPtr_q + AW'(1);
      widx_d  = widx_q + 2'd1;
      if (widx_q == 2'd0) begin
        mode_d = in_encrypt;
      end else if (in_encrypt != mode_q) begin
        violation = 1'b1;
      end
    end

    if (pop) begin
      rdPtr_d = rdPtr_q + AW'(1);
    end

    if (violation) begin
      modeErr_d = 1'b1;
    end else if (err_clr) begin
      modeErr_d = 1'b0;
    end
  end

  // Control state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= '0;
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      widx_q    <= 2'd0;
      mode_q    <= 1'b0;
      modeErr_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      widx_q    <= widx_d;
      mode_q    <= mode_d;
      modeErr_q <= modeErr_d;
    end
  end

  // FIFO storage; cleared on reset so nothing stale survives a restart
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        dataMem_q[i] <= 32'h0;
        encMem_q[i]  <= 1'b0;
        lastMem_q[i] <= 1'b0;
      end
    end else if (push) begin
      dataMem_q[wrPtr_q] <= mappedWord;
      encMem_q[wrPtr_q]  <= in_encrypt;
      lastMem_q[wrPtr_q] <= (widx_q == 2'd3);
    end
  end

endmodule

// File: doc/sbox_preprocess_stream.md
SBOX_PREPROCESS_STREAM -- requirements
Module: sbox_preprocess_stream

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2, output FIFO entries; legal values are powers of two >= 2.
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1, input word valid.
REQ-005 SHALL have port in_ready, output, 1, input word can be accepted.
REQ-006 SHALL have port in_data, input, 32, four state bytes; lane i = in_data[8i+7:8i].
REQ-007 SHALL have port in_encrypt, input, 1; 1 = forward S-box path, 0 = inverse S-box path.
REQ-008 SHALL have port out_valid, output, 1, output word valid.
REQ-009 SHALL have port out_ready, input, 1, downstream accepts the output word.
REQ-010 SHALL have port out_data, output, 32, four mapped composite-field bytes, same lane order as in_data.
REQ-011 SHALL have port out_encrypt, output, 1, in_encrypt captured with that word.
REQ-012 SHALL have port out_last, output, 1, word was the 4th word of a 128-bit block.
REQ-013 SHALL have port err_clr, input, 1, synchronous clear of mode_err.
REQ-014 SHALL have port mode_err, output, 1, sticky flag: mode changed inside a block.

Function
REQ-015 SHALL accept a word when in_valid && in_ready; SHALL emit a word when out_valid && out_ready.
REQ-016 SHALL define delta_inv(k) per output bit: b7=k7^k6^k5^k1, b6=k6^k2, b5=k6^k5^k1, b4=k6^k5^k4^k2^k1, b3=k5^k4^k3^k2^k1, b2=k7^k4^k3^k2^k1, b1=k5^k4, b0=k6^k5^k4^k2^k0.
REQ-017 SHALL define delta as the unique GF(2)-linear map with delta_inv(delta(x)) = x for all 256 x.
REQ-018 SHALL map each lane x as follows. Encrypt: delta(x). Decrypt: delta(InvAff(x)). InvAff(x)_i = x_(i+2 mod 8) ^ x_(i+5 mod 8) ^ x_(i+7 mod 8) ^ c_i, with c = 0x05.
REQ-019 SHALL implement the mapping as fixed XOR logic with no lookup tables. The mapping SHALL be computed combinationally on accept and written into the FIFO together with encrypt and last.
REQ-020 SHALL have a latency of 1 cycle: a word accepted at edge N into an empty FIFO SHALL raise out_valid after edge N.
REQ-021 SHALL drive in_ready = (count < FIFO_DEPTH). When full, in_ready SHALL be 0 even if a pop occurs in the same cycle.
REQ-022 SHALL, on a push and pop in the same cycle, keep count unchanged and keep read/write pointers wrapping modulo FIFO_DEPTH.
REQ-023 SHALL hold out_data, out_encrypt and out_last stable while out_valid && !out_ready.
REQ-024 SHALL keep a 2-bit word index widx, incremented on each accept and wrapping 3 -> 0. out_last of a stored word SHALL be 1 iff widx was 3 when that word was accepted.
REQ-025 SHALL latch the block mode on an accept with widx = 0.
REQ-026 SHALL set mode_err on any accept with widx != 0 and in_encrypt != latched mode. The word SHALL still be mapped using its own in_encrypt.
REQ-027 SHALL resolve err_clr and a new violation in the same cycle in favour of the violation: mode_err = 1.
REQ-028 SHALL ignore in_data and in_encrypt when no accept occurs.

Reset
REQ-029 SHALL, while rst_n = 0, force count = 0, pointers = 0, widx = 0, latched mode = 0, mode_err = 0, out_valid = 0, out_data = 0, out_encrypt = 0, out_last = 0, in_ready = 0.
REQ-030 SHALL assert in_ready = 1 in the first cycle after rst_n deasserts.
REQ-031 SHALL discard FIFO contents and partial-block progress on reset asserted mid-operation; the next accepted word is word 0.

Verification
REQ-032 SHALL cover the exhaustive round-trip: all 256 x in every lane, encrypt=1 -> delta_inv(out byte) = x. The same with encrypt=0 -> delta_inv(out byte) = InvAff(x).
REQ-033 SHALL cover directed values: in_data = 0x00000001, encrypt=1 -> out_data = 0x00000001. in_data = 0x63630063, encrypt=0 -> out_data lanes 0x00, 0x00, x, 0x00, where x = delta(InvAff(0x00)).
REQ-034 SHALL cover backpressure: out_ready = 0 with FIFO_DEPTH = 2 and 3 words offered -> 2 words accepted, in_ready = 0, out_data stable. Then out_ready = 1 -> words emitted in order, 3rd word accepted the cycle after the first pop.
REQ-035 SHALL cover block framing: 8 consecutive words -> out_last = 1 on words 4 and 8 only.
REQ-036 SHALL cover mode errors: word 2 of a block with a flipped in_encrypt -> mode_err = 1 after that edge and still 1 four words later. err_clr pulse -> 0. err_clr coinciding with a new violation -> mode_err stays 1.
REQ-037 SHALL cover reset mid-operation: rst_n low after 2 words with the FIFO holding 1 word -> out_valid = 0 immediately; after release the next word carries out_last only as the 4th word.
